// File: rtl/fifo_push_arbiter.sv
// Round-robin burst arbiter feeding N_REQ requesters into one shared FIFO.
// Optional feature: define ARB_PUSH_COUNT_EN to enable the 16-bit push_count register.
module fifo_push_arbiter #(
  parameter int N_REQ     = 4,
  parameter int N_BITS    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*N_BITS-1:0]   data_in,
  output logic [N_REQ-1:0]          grant,
  input  logic                      fifo_full,
  output logic                      fifo_push,
  output logic [N_BITS-1:0]         fifo_data,
  output logic [15:0]               push_count
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]   owner_q, owner_d;
  logic [7:0]         beat_q, beat_d;
  logic               accept_s;
  logic               pick_vld_s;
  logic [PTR_W-1:0]   pick_s;
  logic [PTR_W-1:0]   owner_next_s;
  logic [N_BITS-1:0]  fifo_data_s;

  assign accept_s     = (|(grant_q & req)) & ~fifo_full;
  assign owner_next_s = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

  // Circular priority scan starting at rr_ptr; scanning downward lets the nearest hit win.
  always_comb begin
    pick_s     = rr_ptr_q;
    pick_vld_s = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      automatic logic [PTR_W-1:0] idx = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
      if (req[idx]) begin
        pick_s     = idx;
        pick_vld_s = 1'b1;
      end else begin
        pick_s     = pick_s;
      end
    end
  end

  // Grant is one-hot or zero, so an AND-OR mux gives zero data when idle.
  always_comb begin
    fifo_data_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      fifo_data_s = fifo_data_s | (data_in[i*N_BITS +: N_BITS] & {N_BITS{grant_q[i]}});
    end
  end

  // Next-state logic: the release path always returns through IDLE, giving the one-cycle bubble.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    case (state_q)
      IDLE: begin
        if (pick_vld_s) begin
          state_d = OWN;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << pick_s;
          owner_d = pick_s;
          beat_d  = 8'd0;
        end else begin
          grant_d = '0;
        end
      end
      OWN: begin
        if (!req[owner_q] || (accept_s && (beat_q == 8'(BURST_LEN - 1)))) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = owner_next_s;
          beat_d   = 8'd0;
        end else if (accept_s) begin
          beat_d = beat_q + 8'd1;
        end else begin
          beat_d = beat_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        beat_d  = 8'd0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      beat_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      beat_q   <= beat_d;
    end
  end

  assign grant     = grant_q;
  assign fifo_push = accept_s;
  assign fifo_data = fifo_data_s;

`ifdef ARB_PUSH_COUNT_EN
  logic [15:0] push_count_q;

  // Free-running accept counter; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_count_q <= 16'd0;
    end else if (accept_s) begin
      push_count_q <= push_count_q + 16'd1;
    end else begin
      push_count_q <= push_count_q;
    end
  end

  assign push_count = push_count_q;
`else
  assign push_count = 16'd0;
`endif

endmodule
